// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control unit:
// FSM states, opcodes, ALU/immediate/mux select codes and the ALU decode helper.
package rv_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR,
    S_LUI, S_AUIPC, S_MD_START, S_MD_WAIT, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MD     = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // IR[30] selects SUB only for register-register ops; for OP-IMM it is immediate bits except on shifts.
  function automatic logic [3:0] alu_dec(input logic [2:0] func3, input logic func7_5,
                                         input logic is_r);
    logic [3:0] r;
    r = ALU_ADD;
    case (func3)
      3'b000:  r = (is_r && func7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = func7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv_branch_cond.sv
// Branch resolution from func3 and the ALU flags of rs1 - rs2.
// carry is the carry-out of A+~B+1, so carry=1 means rs1 >= rs2 unsigned.
module rv_branch_cond #(
  parameter bit BRANCH_FULL = 1'b1
) (
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       neg,
  input  logic       carry,
  input  logic       ovf,
  output logic       taken,
  output logic       illegal
);

  logic lt;
  assign lt = BRANCH_FULL ? (neg ^ ovf) : neg;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  begin taken = BRANCH_FULL & ~carry; illegal = ~BRANCH_FULL; end
      3'b111:  begin taken = BRANCH_FULL & carry;  illegal = ~BRANCH_FULL; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl_gen2.sv
// Multi-cycle RV32 control unit: main FSM, ALU decode and branch resolution.
// State is registered; datapath controls are decoded from state, ready and branch outcome.
module rv_mc_ctrl_gen2 import rv_ctrl_pkg::*; #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit MULDIV_EN   = 1'b1,
  parameter bit BRANCH_FULL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       func7_0,
  input  logic       zero,
  input  logic       neg,
  input  logic       carry,
  input  logic       ovf,
  input  logic       mem_ready,
  input  logic       md_done,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_ctrl,
  output logic       md_start,
  output logic       instr_retire,
  output logic       illegal,
  output logic [4:0] dbg_state
);

  state_t state, state_n;
  logic   illegal_q;
  logic   rdy, br_taken, br_illegal;

  assign rdy       = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign illegal   = illegal_q;
  assign dbg_state = state;

  rv_branch_cond #(.BRANCH_FULL(BRANCH_FULL)) u_branch_cond (
    .func3  (func3),
    .zero   (zero),
    .neg    (neg),
    .carry  (carry),
    .ovf    (ovf),
    .taken  (br_taken),
    .illegal(br_illegal)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (rdy) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_n = S_MEM_ADR;
          OP_R:      state_n = !func7_0 ? S_EXEC_R : (MULDIV_EN ? S_MD_START : S_HALT);
          OP_IMM:    state_n = S_EXEC_I;
          OP_BRANCH: state_n = br_illegal ? S_HALT : S_BRANCH;
          OP_JAL:    state_n = S_JAL;
          OP_JALR:   state_n = S_JALR;
          OP_LUI:    state_n = S_LUI;
          OP_AUIPC:  state_n = S_AUIPC;
          default:   state_n = S_HALT;
        endcase
      end
      S_MEM_ADR:  state_n = (op == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (rdy) state_n = S_MEM_WB;
      S_MEM_WR:   if (rdy) state_n = S_FETCH;
      S_MEM_WB, S_BRANCH, S_ALU_WB: state_n = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR, S_LUI, S_AUIPC: state_n = S_ALU_WB;
      S_MD_START: state_n = S_MD_WAIT;
      S_MD_WAIT:  if (md_done) state_n = S_FETCH;
      S_HALT:     state_n = S_HALT;
      default:    state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == S_HALT) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    pc_write = 1'b0; adr_src = 1'b0; mem_req = 1'b0; mem_write = 1'b0;
    ir_write = 1'b0; reg_write = 1'b0; md_start = 1'b0; instr_retire = 1'b0;
    result_src = RES_ALUOUT; alu_src_a = SRCA_PC; alu_src_b = SRCB_RS2;
    imm_src = IMM_I; alu_ctrl = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1; alu_src_b = SRCB_FOUR; result_src = RES_ALU;
        ir_write = rdy; pc_write = rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM;
        imm_src = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM;
        imm_src = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_RD: begin adr_src = 1'b1; mem_req = 1'b1; end
      S_MEM_WB: begin result_src = RES_MEM; reg_write = 1'b1; instr_retire = 1'b1; end
      S_MEM_WR: begin adr_src = 1'b1; mem_req = 1'b1; mem_write = 1'b1; instr_retire = rdy; end
      S_EXEC_R: begin alu_src_a = SRCA_RS1; alu_ctrl = alu_dec(func3, func7_5, 1'b1); end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM;
        alu_ctrl = alu_dec(func3, func7_5, 1'b0);
      end
      S_ALU_WB: begin reg_write = 1'b1; instr_retire = 1'b1; end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1; alu_ctrl = ALU_SUB; pc_write = br_taken; instr_retire = 1'b1;
      end
      // JAL target was formed in DECODE; this cycle builds the link value OldPC+4.
      S_JAL:   begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR; pc_write = 1'b1; end
      S_JALR:  begin
        alu_src_a = SRCA_RS1; alu_src_b = SRCB_IMM; result_src = RES_ALU; pc_write = 1'b1;
      end
      S_LUI:   begin alu_src_b = SRCB_IMM; imm_src = IMM_U; alu_ctrl = ALU_PASSB; end
      S_AUIPC: begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; imm_src = IMM_U; end
      S_MD_START: begin alu_src_a = SRCA_RS1; md_start = 1'b1; end
      S_MD_WAIT:  begin result_src = RES_MD; reg_write = md_done; instr_retire = md_done; end
      default: ;
    endcase
    if (!rst) begin
      pc_write = 1'b0; adr_src = 1'b0; mem_req = 1'b0; mem_write = 1'b0;
      ir_write = 1'b0; reg_write = 1'b0; md_start = 1'b0; instr_retire = 1'b0;
      result_src = 2'b00; alu_src_a = 2'b00; alu_src_b = 2'b00;
      imm_src = 3'b000; alu_ctrl = 4'b0000;
    end
  end

endmodule

// File: tb/tb_rv_mc_ctrl_gen2.sv
// Directed bench for rv_mc_ctrl_gen2: reset, ALU ops, load stall, branches,
// JAL, MUL handshake, illegal halt and reset during a store stall.
module tb_rv_mc_ctrl_gen2;
  import rv_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic       func7_5, func7_0, zero, neg, carry, ovf, mem_ready, md_done;
  logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic       md_start, instr_retire, illegal;
  logic [4:0] dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int acc;

  always #5 clk = ~clk;

  rv_mc_ctrl_gen2 dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7_5(func7_5), .func7_0(func7_0),
    .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .mem_ready(mem_ready), .md_done(md_done),
    .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
    .md_start(md_start), .instr_retire(instr_retire), .illegal(illegal), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag, input state_t s);
    chk(tag, 32'(dbg_state), 32'(s));
  endtask

  // Each cycle starts 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f75, input logic f70);
    op = o; func3 = f3; func7_5 = f75; func7_0 = f70;
  endtask

  task automatic fetch_decode(input string tag);
    #1;
    chk_st({tag, "_fetch"}, S_FETCH);
    nxt(); #1;
    chk_st({tag, "_decode"}, S_DECODE);
    nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; set_ir(7'd0, 3'd0, 1'b0, 1'b0);
    zero = 0; neg = 0; carry = 0; ovf = 0; mem_ready = 1'b1; md_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk_st("rst_state", S_FETCH);

    // add x3,x1,x2 with zero-wait memory
    rst = 1'b1; set_ir(OP_R, 3'b000, 1'b0, 1'b0);
    #1;
    chk("add_fetch_req", 32'(mem_req), 1);
    chk("add_fetch_irw", 32'(ir_write), 1);
    chk("add_fetch_pcw", 32'(pc_write), 1);
    chk("add_fetch_srcb", 32'(alu_src_b), 2);
    nxt(); #1; chk_st("add_decode", S_DECODE);
    chk("add_decode_imm", 32'(imm_src), 32'(IMM_B));
    nxt(); #1; chk_st("add_exec", S_EXEC_R);
    chk("add_alu", 32'(alu_ctrl), 0);
    chk("add_exec_rw", 32'(reg_write), 0);
    nxt(); #1; chk_st("add_wb", S_ALU_WB);
    chk("add_wb_rw", 32'(reg_write), 1);
    chk("add_wb_ret", 32'(instr_retire), 1);
    chk("add_wb_res", 32'(result_src), 0);

    // sub with one fetch wait state
    nxt(); set_ir(OP_R, 3'b000, 1'b1, 1'b0); mem_ready = 1'b0;
    #1; chk_st("sub_stall_state", S_FETCH);
    chk("sub_stall_irw", 32'(ir_write), 0);
    chk("sub_stall_pcw", 32'(pc_write), 0);
    chk("sub_stall_req", 32'(mem_req), 1);
    nxt(); mem_ready = 1'b1;
    #1; chk("sub_fetch_irw", 32'(ir_write), 1);
    nxt(); nxt(); #1; chk("sub_alu", 32'(alu_ctrl), 1);
    nxt(); nxt();

    // addi with IR[30]=1 must stay ADD
    set_ir(OP_IMM, 3'b000, 1'b1, 1'b0);
    fetch_decode("addi");
    #1; chk_st("addi_exec", S_EXEC_I);
    chk("addi_alu", 32'(alu_ctrl), 0);
    chk("addi_srcb", 32'(alu_src_b), 1);
    nxt(); nxt();

    // srai
    set_ir(OP_IMM, 3'b101, 1'b1, 1'b0);
    fetch_decode("srai");
    #1; chk("srai_alu", 32'(alu_ctrl), 9);
    nxt(); nxt();

    // lw with mem_ready low for 3 cycles in MEM_RD, retire in cycle 8
    set_ir(OP_LOAD, 3'b010, 1'b0, 1'b0);
    fetch_decode("lw");
    #1; chk_st("lw_adr", S_MEM_ADR);
    chk("lw_adr_srca", 32'(alu_src_a), 2);
    chk("lw_adr_imm", 32'(imm_src), 32'(IMM_I));
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      nxt(); mem_ready = 1'b0;
      #1; chk_st("lw_rd_hold", S_MEM_RD);
      chk("lw_rd_adr", 32'(adr_src), 1);
      acc += int'(reg_write) + int'(instr_retire);
    end
    nxt(); mem_ready = 1'b1;
    #1; chk_st("lw_rd_ready", S_MEM_RD);
    acc += int'(reg_write);
    chk("lw_no_early_write", 32'(acc), 0);
    nxt(); #1; chk_st("lw_wb", S_MEM_WB);
    chk("lw_wb_rw", 32'(reg_write), 1);
    chk("lw_wb_res", 32'(result_src), 1);
    chk("lw_wb_ret", 32'(instr_retire), 1);
    nxt();

    // bltu: carry=0 taken, carry=1 not taken
    set_ir(OP_BRANCH, 3'b110, 1'b0, 1'b0); carry = 1'b0;
    fetch_decode("bltu0");
    #1; chk_st("bltu0_state", S_BRANCH);
    chk("bltu0_pcw", 32'(pc_write), 1);
    chk("bltu0_ret", 32'(instr_retire), 1);
    chk("bltu0_alu", 32'(alu_ctrl), 1);
    nxt(); carry = 1'b1;
    fetch_decode("bltu1");
    #1; chk("bltu1_pcw", 32'(pc_write), 0);
    chk("bltu1_ret", 32'(instr_retire), 1);
    nxt();

    // blt with neg=0, ovf=1 is a signed less-than
    set_ir(OP_BRANCH, 3'b100, 1'b0, 1'b0); carry = 1'b0; neg = 1'b0; ovf = 1'b1;
    fetch_decode("blt");
    #1; chk("blt_pcw", 32'(pc_write), 1);
    nxt(); ovf = 1'b0;

    // JAL
    set_ir(OP_JAL, 3'b000, 1'b0, 1'b0);
    #1; chk_st("jal_fetch", S_FETCH);
    nxt(); #1; chk("jal_decode_imm", 32'(imm_src), 32'(IMM_J));
    nxt(); #1; chk_st("jal_state", S_JAL);
    chk("jal_pcw", 32'(pc_write), 1);
    chk("jal_srcb", 32'(alu_src_b), 2);
    nxt(); #1; chk("jal_wb_ret", 32'(instr_retire), 1);
    nxt();

    // mul: md_done in MD_START ignored, real done five cycles after start
    set_ir(OP_R, 3'b000, 1'b0, 1'b1);
    fetch_decode("mul");
    md_done = 1'b1;
    #1; chk_st("mul_start", S_MD_START);
    acc = int'(md_start);
    for (int i = 0; i < 4; i++) begin
      nxt(); md_done = 1'b0;
      #1; chk_st("mul_wait", S_MD_WAIT);
      chk("mul_wait_ret", 32'(instr_retire), 0);
      acc += int'(md_start);
    end
    nxt(); md_done = 1'b1;
    #1; chk("mul_done_rw", 32'(reg_write), 1);
    chk("mul_done_res", 32'(result_src), 3);
    chk("mul_done_ret", 32'(instr_retire), 1);
    acc += int'(md_start);
    chk("mul_start_pulses", 32'(acc), 1);
    nxt(); md_done = 1'b0;
    #1; chk_st("mul_back_fetch", S_FETCH);

    // store stalled in MEM_WR, aborted by reset
    set_ir(OP_STORE, 3'b010, 1'b0, 1'b0);
    fetch_decode("sw");
    #1; chk("sw_adr_imm", 32'(imm_src), 32'(IMM_S));
    nxt(); mem_ready = 1'b0;
    #1; chk_st("sw_wr", S_MEM_WR);
    chk("sw_wr_strobe", 32'(mem_write), 1);
    chk("sw_wr_ret", 32'(instr_retire), 0);
    nxt(); #2;
    rst = 1'b0;
    #1; chk("sw_rst_write", 32'(mem_write), 0);
    chk("sw_rst_req", 32'(mem_req), 0);
    chk("sw_rst_adr", 32'(adr_src), 0);
    nxt(); rst = 1'b1; mem_ready = 1'b1; set_ir(OP_R, 3'b000, 1'b0, 1'b0);
    #1; chk_st("sw_after_fetch", S_FETCH);
    acc = int'(mem_write);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1; acc += int'(mem_write);
    end
    chk("sw_no_reissue", 32'(acc), 0);
    chk("sw_after_ret", 32'(instr_retire), 1);
    nxt();

    // illegal opcode halts until reset
    set_ir(7'b0000000, 3'b000, 1'b0, 1'b0);
    #1; chk_st("ill_fetch", S_FETCH);
    nxt(); #1; chk("ill_decode_flag", 32'(illegal), 0);
    nxt(); #1; chk_st("ill_halt", S_HALT);
    chk("ill_flag", 32'(illegal), 1);
    acc = int'(mem_req) + int'(instr_retire);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1; acc += int'(mem_req) + int'(instr_retire);
    end
    chk("ill_quiet", 32'(acc), 0);
    chk("ill_sticky", 32'(illegal), 1);
    #2; rst = 1'b0;
    #1; chk("ill_rst_clear", 32'(illegal), 0);
    nxt(); rst = 1'b1;

    // branch func3=010 is an illegal encoding
    set_ir(OP_BRANCH, 3'b010, 1'b0, 1'b0);
    #1; chk("brill_fetch_req", 32'(mem_req), 1);
    nxt(); nxt(); #1; chk_st("brill_halt", S_HALT);
    chk("brill_flag", 32'(illegal), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
